// File: rtl/dpbram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : dpbram_stream_reader
//  Function : Reads a block of words (wrapping at DP) from one port of an
//             N x DW dual-port BRAM and streams them out as valid/ready beats.
//  Revision : 1.0  initial release
// ============================================================================
module dpbram_stream_reader #(
    parameter int DP  = 512,
    parameter int DW  = 8,
    parameter int N   = 3,
    parameter int AW  = $clog2(DP) - 1,
    parameter int BDW = N * DW - 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW:0]   base,
    input  logic [AW+1:0] len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          mem_ce,
    output logic          mem_wr,
    output logic [AW:0]   mem_addr,
    input  logic [BDW:0]  mem_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [BDW:0]  m_data,
    output logic          m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0]   c_last_addr = (AW + 1)'(DP - 1);
    localparam logic [AW:0]   c_addr_one  = (AW + 1)'(1);
    localparam logic [AW+1:0] c_len_one   = (AW + 2)'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_launch;
    logic          w_flush;

    logic [AW:0]   r_rd_ptr;
    logic [AW+1:0] r_len;
    logic [AW+1:0] r_issued;
    logic [AW+1:0] r_beat_cnt;
    logic [AW+1:0] w_len_m1;
    logic          r_inflight;

    logic [BDW:0]  r_fifo_mem [0:1];
    logic          r_wr_sel;
    logic          r_rd_sel;
    logic [1:0]    r_count;

    logic          w_pop;
    logic          w_issue;
    logic          w_head_last;
    logic [2:0]    w_occ;

    // ------------------------------------------------------------------------
    // Issue credit: words held in the FIFO plus the read in flight, less the
    // beat leaving this cycle, must stay below the FIFO depth of two.
    // ------------------------------------------------------------------------
    assign w_len_m1    = r_len - c_len_one;
    assign w_pop       = m_valid & m_ready;
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_head_last = (r_beat_cnt == w_len_m1);
    assign w_issue     = (r_state == RUN) & ~abort & (r_issued != r_len) &
                         (w_occ < (3'd2 + {2'b00, w_pop}));

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign mem_ce   = w_issue;
    assign mem_wr   = 1'b0;
    assign mem_addr = r_rd_ptr;
    assign m_valid  = (r_count != 2'd0);
    assign m_data   = m_valid ? r_fifo_mem[r_rd_sel] : '0;
    assign m_last   = m_valid & w_head_last;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_launch    = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_state_nxt = RUN;
                        w_launch    = 1'b1;
                        w_flush     = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_flush     = 1'b1;
                end else if (w_issue && (r_issued == w_len_m1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_flush     = 1'b1;
                end else if (w_pop && w_head_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_flush     = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read pointer and transfer counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr   <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_launch) begin
                r_rd_ptr <= base;
                r_len    <= len;
                r_issued <= '0;
            end else if (w_issue) begin
                r_rd_ptr <= (r_rd_ptr == c_last_addr) ? '0 : (r_rd_ptr + c_addr_one);
                r_issued <= r_issued + c_len_one;
            end
            r_inflight <= w_issue;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_cnt <= '0;
        end else if (w_launch) begin
            r_beat_cnt <= '0;
        end else if (w_pop && !w_flush) begin
            r_beat_cnt <= r_beat_cnt + c_len_one;
        end
    end

    // ------------------------------------------------------------------------
    // Two-entry output FIFO; a flush also drops the read still in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_mem[i] <= '0;
            end
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_count  <= 2'd0;
        end else if (w_flush) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_mem[r_wr_sel] <= mem_rdata;
                r_wr_sel             <= ~r_wr_sel;
            end
            if (w_pop) begin
                r_rd_sel <= ~r_rd_sel;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpbram_stream_reader.sv
`default_nettype none
// Bench for dpbram_stream_reader: RAM model, expected-stream model and
// directed scenarios with hand-computed values.
module tb_dpbram_stream_reader;
    localparam int DP  = 512;
    localparam int DW  = 8;
    localparam int N   = 3;
    localparam int AW  = $clog2(DP) - 1;
    localparam int BDW = N * DW - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   base = '0;
    logic [AW+1:0] len = '0;
    logic          abort = 1'b0;
    logic          busy, done, mem_ce, mem_wr, m_valid, m_last;
    logic [AW:0]   mem_addr;
    logic [BDW:0]  mem_rdata = '0;
    logic          m_ready = 1'b0;
    logic [BDW:0]  m_data;

    logic [BDW:0]  ram [0:DP-1];

    always #5 clk = ~clk;

    dpbram_stream_reader #(.DP(DP), .DW(DW), .N(N)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base(base), .len(len),
        .abort(abort), .busy(busy), .done(done), .mem_ce(mem_ce),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    // RAM read port: one cycle latency
    always @(posedge clk) if (mem_ce) mem_rdata <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected-behaviour model
    logic [BDW:0] exp_q[$];
    bit           exp_last_q[$];
    logic [AW:0]  addr_q[$];
    logic [BDW:0] got_q[$];
    logic [AW:0]  got_addr_q[$];
    bit           mdl_busy = 0;
    int           exp_done_cyc = -10;
    int           issued = 0, accepted = 0;
    int           start_cyc = -1, first_ce_cyc = -1, first_valid_cyc = -1, done_seen_cyc = -1;
    bit           prev_hold = 0;
    logic [BDW:0] prev_data = '0;

    always @(negedge clk) begin : monitor
        bit busy_now;
        if (!rstn) begin
            exp_q.delete(); exp_last_q.delete(); addr_q.delete();
            mdl_busy = 0; exp_done_cyc = -10; issued = 0; accepted = 0; prev_hold = 0;
        end else begin
            busy_now = mdl_busy;
            chk("mem_wr", {31'b0, mem_wr}, 0);
            chk("busy", {31'b0, busy}, {31'b0, busy_now});
            chk("done", {31'b0, done}, (cyc == exp_done_cyc) ? 1 : 0);
            if (done) done_seen_cyc = cyc;
            if (prev_hold) begin
                chk("hold_valid", {31'b0, m_valid}, 1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (busy_now && abort) begin
                exp_q.delete(); exp_last_q.delete(); addr_q.delete();
                mdl_busy = 0; prev_hold = 0;
            end else begin
                if (mem_ce) begin
                    if (first_ce_cyc < 0) first_ce_cyc = cyc;
                    got_addr_q.push_back(mem_addr);
                    if (addr_q.size() == 0) chk("spurious_issue", 1, 0);
                    else chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                    issued++;
                end
                if (m_valid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
                    else begin
                        chk("m_data", 32'(m_data), 32'(exp_q[0]));
                        chk("m_last", {31'b0, m_last}, {31'b0, exp_last_q[0]});
                        if (m_ready) begin
                            got_q.push_back(m_data);
                            accepted++;
                            if (exp_last_q[0]) begin
                                mdl_busy = 0;
                                exp_done_cyc = cyc + 1;
                            end
                            void'(exp_q.pop_front());
                            void'(exp_last_q.pop_front());
                        end
                    end
                end
                if (busy_now) chk("outstanding", ((issued - accepted) <= 2) ? 1 : 0, 1);
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
                if (!busy_now && start) begin
                    start_cyc = cyc;
                    if (len == '0) exp_done_cyc = cyc + 1;
                    else begin
                        mdl_busy = 1; issued = 0; accepted = 0;
                        for (int i = 0; i < int'(len); i++) begin
                            exp_q.push_back(ram[(int'(base) + i) % DP]);
                            exp_last_q.push_back(i == int'(len) - 1);
                            addr_q.push_back((AW + 1)'((int'(base) + i) % DP));
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int l);
        got_q.delete(); got_addr_q.delete();
        first_ce_cyc = -1; first_valid_cyc = -1; done_seen_cyc = -1; start_cyc = -1;
        base = (AW + 1)'(b);
        len = (AW + 2)'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name, input bit rnd);
        int k = 0;
        while ((busy || mdl_busy) && k < maxc) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        if (k >= maxc) chk({name, "_timeout"}, 0, 1);
        m_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        for (int i = 0; i < DP; i++) ram[i] = (BDW + 1)'(i * 32'h010101);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_mem_ce", {31'b0, mem_ce}, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_m_valid", {31'b0, m_valid}, 0);
        chk("rst_m_last", {31'b0, m_last}, 0);
        chk("rst_m_data", 32'(m_data), 0);
        rstn = 1'b1;
        m_ready = 1'b1;
        tick();

        // Basic transfer with hand-computed words and timing
        do_start(10, 4);
        wait_idle(50, "t1", 0);
        chk("t1_beats", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("t1_w0", 32'(got_q[0]), 32'h0A0A0A);
            chk("t1_w1", 32'(got_q[1]), 32'h0B0B0B);
            chk("t1_w2", 32'(got_q[2]), 32'h0C0C0C);
            chk("t1_w3", 32'(got_q[3]), 32'h0D0D0D);
        end
        chk("t1_first_ce", first_ce_cyc - start_cyc, 1);
        chk("t1_first_valid", first_valid_cyc - start_cyc, 3);
        chk("t1_done", done_seen_cyc - start_cyc, 7);

        // Address wrap-around
        do_start(510, 4);
        wait_idle(50, "wrap", 0);
        chk("wrap_issues", got_addr_q.size(), 4);
        if (got_addr_q.size() == 4) begin
            chk("wrap_a0", 32'(got_addr_q[0]), 510);
            chk("wrap_a1", 32'(got_addr_q[1]), 511);
            chk("wrap_a2", 32'(got_addr_q[2]), 0);
            chk("wrap_a3", 32'(got_addr_q[3]), 1);
        end

        // Random backpressure
        do_start(77, 64);
        wait_idle(2000, "bp", 1);
        chk("bp_beats", got_q.size(), 64);

        // Zero length
        do_start(5, 0);
        wait_idle(10, "len0", 0);
        chk("len0_done", done_seen_cyc - start_cyc, 1);
        chk("len0_issues", got_addr_q.size(), 0);
        chk("len0_beats", got_q.size(), 0);

        // Full-depth transfer
        do_start(37, DP);
        wait_idle(DP + 50, "full", 0);
        chk("full_beats", got_q.size(), DP);
        if (got_addr_q.size() == DP) chk("full_last_addr", 32'(got_addr_q[DP-1]), 36);

        // Back-to-back: second start issued in the done cycle
        do_start(10, 2);
        k = 0;
        while (!done && k < 50) begin tick(); k++; end
        if (k >= 50) chk("b2b_timeout", 0, 1);
        do_start(20, 2);
        chk("b2b_accepted", {31'b0, busy}, 1);
        wait_idle(50, "b2b", 0);
        if (got_q.size() == 2) chk("b2b_w0", 32'(got_q[0]), 32'h141414);
        else chk("b2b_beats", got_q.size(), 2);

        // Abort with full FIFO under backpressure
        do_start(100, 8);
        k = 0;
        while (accepted < 3 && k < 50) begin tick(); k++; end
        if (k >= 50) chk("abort_wait_timeout", 0, 1);
        m_ready = 1'b0;
        repeat (3) tick();
        chk("abort_fifo_full", issued - accepted, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", {31'b0, m_valid}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        repeat (3) tick();
        m_ready = 1'b1;
        do_start(0, 2);
        wait_idle(50, "post_abort", 0);
        chk("pa_beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("pa_w0", 32'(got_q[0]), 32'h000000);
            chk("pa_w1", 32'(got_q[1]), 32'h010101);
        end

        // Ignored start mid-transfer, then asynchronous reset
        do_start(50, 16);
        repeat (3) tick();
        base = (AW + 1)'(300);
        len = (AW + 2)'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_mem_ce", {31'b0, mem_ce}, 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_m_valid", {31'b0, m_valid}, 0);
        chk("arst_m_data", 32'(m_data), 0);
        chk("arst_m_last", {31'b0, m_last}, 0);
        chk("arst_done", {31'b0, done}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        do_start(200, 3);
        wait_idle(50, "post_rst", 0);
        chk("pr_beats", got_q.size(), 3);
        if (got_q.size() == 3) chk("pr_w0", 32'(got_q[0]), 32'hC8C8C8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
